serial_symbol_framer: RTL and testbench

//  Upstream stage of the stream-detect FSM: deserializes a serial bit stream into WIDTH-bit symbols.

---
 rtl/serial_symbol_framer_pkg.sv | 21 ++
 rtl/serial_symbol_framer_fifo.sv | 62 ++++++
 rtl/serial_symbol_framer.sv | 139 +++++++++++++
 tb/tb_serial_symbol_framer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_symbol_framer_pkg.sv
// Shared definitions for the serial symbol framer: FSM state encoding,
// default symbol width / sync word, and the symbol-length derivation macro.
// Optional feature macro: SYMBOL_PARITY_EN (adds one even-parity bit per symbol).

`ifdef SYMBOL_PARITY_EN
  `define STREAM_SYM_BITS(w) ((w) + 1)
`else
  `define STREAM_SYM_BITS(w) (w)
`endif

package stream_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int         WIDTH_DEF     = 4;
  localparam logic [3:0] SYNC_WORD_DEF = 4'b1010;

endpackage

// File: rtl/serial_symbol_framer_fifo.sv
// symbol_fifo: small circular buffer with valid/ready output.
// Push is accepted when there is room or the head is popped the same cycle;
// otherwise the incoming symbol is dropped and o_drop is raised.

module symbol_fifo #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop, w_push_ok;

  assign o_valid   = (r_count != '0);
  assign w_pop     = o_valid & i_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign w_push_ok = i_push & ((r_count < FULL_CNT) | w_pop);
  assign o_drop    = i_push & ~w_push_ok;
  assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

  // Storage write on accepted push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_symbol_framer.sv
// serial_symbol_framer: hunts a serial stream for SYNC_WORD, then slices the
// following FRAME_LEN symbols (MSB first) into a small output FIFO.
// Completed symbols are staged one cycle before entering the FIFO.
// Optional feature macro: SYMBOL_PARITY_EN (trailing even-parity bit per symbol).

module serial_symbol_framer
  import stream_pkg::*;
#(
  parameter int               WIDTH      = WIDTH_DEF,
  parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(SYNC_WORD_DEF),
  parameter int               FRAME_LEN  = 8,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bit,
  input  logic             i_bit_valid,
  output logic [WIDTH-1:0] o_symbol,
  output logic             o_symbol_valid,
  input  logic             i_symbol_ready,
  output logic             o_locked,
  output logic             o_overflow,
  output logic             o_parity_err
);

  localparam int SYM_BITS = `STREAM_SYM_BITS(WIDTH);
  // Only the bits needed to form the next symbol/sync compare are kept.
  localparam int SR_W     = SYM_BITS - 1;
  localparam int BW       = $clog2(SYM_BITS);
  localparam int SW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(SYM_BITS - 1);
  localparam logic [SW-1:0] LAST_SYM = SW'(FRAME_LEN - 1);

  state_e           r_state, w_state_nxt;
  logic [SR_W-1:0]  r_sr;
  logic [BW-1:0]    r_bit_cnt;
  logic [SW-1:0]    r_sym_cnt;
  logic [WIDTH-1:0] w_sr_shift;
  logic [WIDTH-1:0] w_sym_data;
  logic             w_sync_hit, w_sym_done, w_last_sym, w_par_ok;
  logic             r_cmp_vld;
  logic [WIDTH-1:0] r_cmp_sym;

  assign w_sr_shift = {r_sr[WIDTH-2:0], i_bit};
  assign w_sync_hit = (r_state == HUNT) & i_bit_valid & (w_sr_shift == SYNC_WORD);
  assign w_sym_done = (r_state == LOCKED) & i_bit_valid & (r_bit_cnt == LAST_BIT);
  assign w_last_sym = (r_sym_cnt == LAST_SYM);
  assign o_locked   = (r_state == LOCKED);

`ifdef SYMBOL_PARITY_EN
  logic r_cmp_perr;
  // Data bits are already in the shift register when the parity bit arrives.
  assign w_sym_data   = r_sr;
  assign w_par_ok     = ~(^{r_sr, i_bit});
  assign o_parity_err = r_cmp_perr;

  // Parity-fail pulse lines up with the cycle the push would have happened.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cmp_perr <= 1'b0;
    else          r_cmp_perr <= w_sym_done & ~w_par_ok;
  end
`else
  assign w_sym_data   = w_sr_shift;
  assign w_par_ok     = 1'b1;
  assign o_parity_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= HUNT;
    else          r_state <= w_state_nxt;
  end

  // Next-state: lock on sync, drop back to hunting after the last frame symbol.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HUNT:    if (w_sync_hit) w_state_nxt = LOCKED;
      LOCKED:  if (w_sym_done && w_last_sym) w_state_nxt = HUNT;
      default: w_state_nxt = HUNT;
    endcase
  end

  // Shift register and bit/symbol counters; the shift register is cleared at
  // frame end so re-sync needs a complete fresh sync word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_sym_cnt <= '0;
    end else if (i_bit_valid) begin
      if (r_state == HUNT) begin
        r_sr <= w_sr_shift[SR_W-1:0];
        if (w_sync_hit) begin
          r_bit_cnt <= '0;
          r_sym_cnt <= '0;
        end
      end else if (w_sym_done) begin
        r_bit_cnt <= '0;
        if (w_last_sym) begin
          r_sr      <= '0;
          r_sym_cnt <= '0;
        end else begin
          r_sr      <= w_sr_shift[SR_W-1:0];
          r_sym_cnt <= r_sym_cnt + 1'b1;
        end
      end else begin
        r_sr      <= w_sr_shift[SR_W-1:0];
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // One-cycle staging of completed symbols ahead of the FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmp_vld <= 1'b0;
      r_cmp_sym <= '0;
    end else begin
      r_cmp_vld <= w_sym_done & w_par_ok;
      if (w_sym_done) r_cmp_sym <= w_sym_data;
    end
  end

  symbol_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_cmp_vld),
    .i_data  (r_cmp_sym),
    .i_ready (i_symbol_ready),
    .o_data  (o_symbol),
    .o_valid (o_symbol_valid),
    .o_drop  (o_overflow)
  );

endmodule

// File: tb/tb_serial_symbol_framer.sv
// Bench for serial_symbol_framer: directed vectors, a queue-based framing
// model compared every cycle, plus literal expectations per scenario.
// Build with SYMBOL_PARITY_EN defined to exercise the parity variant.

module tb_serial_symbol_framer;

  localparam int         WIDTH      = 4;
  localparam logic [3:0] SYNC       = 4'b1010;
  localparam int         FRAME_LEN  = 8;
  localparam int         FIFO_DEPTH = 2;
`ifdef SYMBOL_PARITY_EN
  localparam int SYM_BITS = WIDTH + 1;
  localparam bit PAR      = 1'b1;
`else
  localparam int SYM_BITS = WIDTH;
  localparam bit PAR      = 1'b0;
`endif

  logic             clk, rst_n;
  logic             i_bit, i_bit_valid, i_symbol_ready;
  logic [WIDTH-1:0] o_symbol;
  logic             o_symbol_valid, o_locked, o_overflow, o_parity_err;

  serial_symbol_framer #(
    .WIDTH      (WIDTH),
    .SYNC_WORD  (SYNC),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_bit          (i_bit),
    .i_bit_valid    (i_bit_valid),
    .o_symbol       (o_symbol),
    .o_symbol_valid (o_symbol_valid),
    .i_symbol_ready (i_symbol_ready),
    .o_locked       (o_locked),
    .o_overflow     (o_overflow),
    .o_parity_err   (o_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int n_pop = 0, n_ovf = 0, n_perr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_locked;
  int m_hist, m_cur, m_n, m_nsym;
  int q[$];
  bit pend_vld, pend_perr;
  int pend_sym;

  task automatic m_clear();
    m_locked = 0; m_hist = 0; m_cur = 0; m_n = 0; m_nsym = 0;
    q.delete(); pend_vld = 0; pend_perr = 0; pend_sym = 0;
  endtask

  task automatic m_frame(input bit b);
    if (!m_locked) begin
      m_hist = ((m_hist << 1) | int'(b)) & ((1 << WIDTH) - 1);
      if (m_hist == int'(SYNC)) begin
        m_locked = 1; m_cur = 0; m_n = 0; m_nsym = 0;
      end
    end else begin
      m_cur = (m_cur << 1) | int'(b);
      m_n++;
      if (m_n == SYM_BITS) begin
        if (PAR) begin
          pend_perr = ($countones(m_cur) % 2) != 0;
          pend_sym  = m_cur >> 1;
        end else begin
          pend_perr = 0;
          pend_sym  = m_cur;
        end
        pend_vld = !pend_perr;
        m_cur = 0; m_n = 0; m_nsym++;
        if (m_nsym == FRAME_LEN) begin
          m_locked = 0; m_hist = 0;
        end
      end
    end
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_clear();
      else begin
        if (q.size() > 0 && i_symbol_ready) void'(q.pop_front());
        if (pend_vld && q.size() < FIFO_DEPTH) q.push_back(pend_sym);
        pend_vld = 0; pend_perr = 0;
        if (i_bit_valid) m_frame(i_bit);
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("valid",      o_symbol_valid, q.size() > 0);
      chk("symbol",     o_symbol,       q.size() > 0 ? q[0] : 0);
      chk("locked",     o_locked,       m_locked);
      chk("overflow",   o_overflow,     pend_vld && q.size() >= FIFO_DEPTH && !i_symbol_ready);
      chk("parity_err", o_parity_err,   pend_perr);
      if (o_symbol_valid && i_symbol_ready) n_pop++;
      if (o_overflow)   n_ovf++;
      if (o_parity_err) n_perr++;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b);
    i_bit = b; i_bit_valid = 1'b1;
    @(posedge clk); #1;
    i_bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_sym(input logic [WIDTH-1:0] d);
    send_bits({4'b0, d}, WIDTH);
    if (PAR) send_bit(^d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; idle(2); rst_n = 1'b1;
  endtask

  int base;

  initial begin
    rst_n = 1'b0; i_bit = 1'b0; i_bit_valid = 1'b0; i_symbol_ready = 1'b1;

    // 1: reset held while bits toggle, then release without sync
    repeat (4) begin @(posedge clk); #1; i_bit = ~i_bit; i_bit_valid = 1'b1; end
    chk("t1_valid_rst",  o_symbol_valid, 0);
    chk("t1_symbol_rst", o_symbol,       0);
    chk("t1_locked_rst", o_locked,       0);
    chk("t1_ovf_rst",    o_overflow,     0);
    i_bit_valid = 1'b0;
    idle(1); rst_n = 1'b1;
    send_bits(8'b1100, 4);
    chk("t1_locked_nosync", o_locked, 0);
    chk("t1_valid_nosync",  o_symbol_valid, 0);

    // 2: sync + one symbol, consumer ready
    do_reset();
    send_bits({4'b0, SYNC}, 4);
    chk("t2_locked", o_locked, 1);
    send_sym(4'b0001);
    chk("t2_valid_early", o_symbol_valid, 0);
    idle(1);
    chk("t2_valid", o_symbol_valid, 1);
    chk("t2_symbol", o_symbol, 4'b0001);
    idle(1);
    chk("t2_valid_gone", o_symbol_valid, 0);

    // 3: full frame then non-sync bits
    do_reset();
    base = n_pop;
    send_bits({4'b0, SYNC}, 4);
    repeat (FRAME_LEN) send_sym(4'b0001);
    chk("t3_unlocked", o_locked, 0);
    idle(3);
    chk("t3_count", n_pop - base, FRAME_LEN);
    send_bits(8'b0001, 4);
    idle(4);
    chk("t3_count_after", n_pop - base, FRAME_LEN);
    chk("t3_unlocked_after", o_locked, 0);

    // 4: backpressure overflow
    do_reset();
    i_symbol_ready = 1'b0;
    base = n_ovf;
    send_bits({4'b0, SYNC}, 4);
    send_sym(4'h1); send_sym(4'h2); send_sym(4'h3);
    idle(3);
    chk("t4_ovf_pulses", n_ovf - base, 1);
    chk("t4_head_valid", o_symbol_valid, 1);
    chk("t4_head_hold", o_symbol, 4'h1);
    i_symbol_ready = 1'b1;
    chk("t4_first", o_symbol, 4'h1);
    idle(1);
    chk("t4_second", o_symbol, 4'h2);
    chk("t4_second_valid", o_symbol_valid, 1);
    idle(1);
    chk("t4_drained", o_symbol_valid, 0);

    // 5: reset mid-symbol
    do_reset();
    base = n_pop;
    send_bits({4'b0, SYNC}, 4);
    send_bit(1'b0); send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_async_unlock", o_locked, 0);
    chk("t5_valid", o_symbol_valid, 0);
    idle(2); rst_n = 1'b1;
    send_bits(8'b0001, 4);
    idle(3);
    chk("t5_no_emit", n_pop - base, 0);
    chk("t5_locked", o_locked, 0);

`ifdef SYMBOL_PARITY_EN
    // 6: good then bad parity
    do_reset();
    base = n_pop;
    send_bits({4'b0, SYNC}, 4);
    send_bits(8'b00011, 5);
    send_bits(8'b00010, 5);
    idle(3);
    chk("t6_emitted", n_pop - base, 1);
    chk("t6_perr", n_perr, 1);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
